// File: rtl/vga_term_writer.sv
// Byte-stream terminal front end for the VGA text buffer: decodes ASCII and control
// codes into single-cycle character-buffer writes and keeps the on-screen cursor.
module vga_term_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [12:0] ascii_address,
    output logic [7:0]  ascii_data,
    output logic        ascii_wr_en,
    output logic [12:0] cursor,
    output logic        busy
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
    localparam logic [12:0]   COLS_A      = 13'(COLS);
    localparam logic [12:0]   LINE_LAST   = 13'(COLS - 1);
    localparam logic [12:0]   SCREEN_LAST = 13'(COLS * ROWS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, LINECLR} state_t;

    state_t        state, state_d;
    logic [CW-1:0] col, col_d;
    logic [RW-1:0] row, row_d;
    logic [12:0]   row_base, base_d;
    logic [12:0]   clr_ptr, ptr_d;
    logic [7:0]    wr_byte, byte_d;
    logic          wr_adv, adv_d;
    logic [12:0]   addr_d, cursor_d;
    logic [7:0]    data_d;
    logic          we_d, ready_d, busy_d;
    logic          accept;
    logic [RW-1:0] row_inc;
    logic [12:0]   base_inc;

    assign accept = rx_valid && rx_ready;

    // Row advance wraps to the top of the screen instead of scrolling.
    assign row_inc  = (row == ROW_LAST) ? '0 : row + 1'b1;
    assign base_inc = (row == ROW_LAST) ? '0 : row_base + COLS_A;

    always_comb begin
        state_d = state;
        col_d   = col;
        row_d   = row;
        base_d  = row_base;
        ptr_d   = clr_ptr;
        byte_d  = wr_byte;
        adv_d   = wr_adv;
        we_d    = 1'b0;
        addr_d  = ascii_address;
        data_d  = ascii_data;
        case (state)
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_ptr;
                data_d = 8'h00;
                if (clr_ptr == SCREEN_LAST) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                end else begin
                    ptr_d = clr_ptr + 13'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        byte_d  = rx_data;
                        adv_d   = 1'b1;
                        state_d = WRITE;
                    end else if (rx_data == 8'h0A) begin
                        col_d   = '0;
                        row_d   = row_inc;
                        base_d  = base_inc;
                        ptr_d   = '0;
                        state_d = LINECLR;
                    end else if (rx_data == 8'h0D) begin
                        col_d = '0;
                    end else if (rx_data == 8'h08) begin
                        // Backspace erases in place and never leaves the current row.
                        if (col != '0) begin
                            col_d   = col - 1'b1;
                            byte_d  = 8'h00;
                            adv_d   = 1'b0;
                            state_d = WRITE;
                        end
                    end else if (rx_data == 8'h0C) begin
                        col_d   = '0;
                        row_d   = '0;
                        base_d  = '0;
                        ptr_d   = '0;
                        state_d = CLEAR;
                    end
                end
            end
            WRITE: begin
                we_d    = 1'b1;
                addr_d  = cursor;
                data_d  = wr_byte;
                state_d = IDLE;
                if (wr_adv) begin
                    if (col == COL_LAST) begin
                        col_d   = '0;
                        row_d   = row_inc;
                        base_d  = base_inc;
                        ptr_d   = '0;
                        state_d = LINECLR;
                    end else begin
                        col_d = col + 1'b1;
                    end
                end
            end
            LINECLR: begin
                we_d   = 1'b1;
                addr_d = row_base + clr_ptr;
                data_d = 8'h00;
                if (clr_ptr == LINE_LAST) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = clr_ptr + 13'd1;
                end
            end
            default: state_d = CLEAR;
        endcase
        cursor_d = base_d + 13'(col_d);
        // Ready reopens one cycle after a clear's final write has left the output register.
        ready_d  = (state_d == IDLE) && !accept && (state != CLEAR) && (state != LINECLR);
        busy_d   = (state_d == CLEAR) || (state_d == LINECLR) ||
                   (state == CLEAR) || (state == LINECLR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CLEAR;
            col           <= '0;
            row           <= '0;
            row_base      <= '0;
            clr_ptr       <= '0;
            wr_byte       <= '0;
            wr_adv        <= 1'b0;
            rx_ready      <= 1'b0;
            ascii_address <= '0;
            ascii_data    <= '0;
            ascii_wr_en   <= 1'b0;
            cursor        <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            col           <= col_d;
            row           <= row_d;
            row_base      <= base_d;
            clr_ptr       <= ptr_d;
            wr_byte       <= byte_d;
            wr_adv        <= adv_d;
            rx_ready      <= ready_d;
            ascii_address <= addr_d;
            ascii_data    <= data_d;
            ascii_wr_en   <= we_d;
            cursor        <= cursor_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_vga_term_writer.sv
// Randomized bench for vga_term_writer: a row/col terminal model predicts every buffer
// write into a queue that a negedge monitor drains, and cursor/latency are checked per byte.
module tb_vga_term_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int SCREEN = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [12:0] ascii_address;
    logic [7:0]  ascii_data;
    logic        ascii_wr_en;
    logic [12:0] cursor;
    logic        busy;

    vga_term_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ascii_address(ascii_address), .ascii_data(ascii_data), .ascii_wr_en(ascii_wr_en),
        .cursor(cursor), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_seen = 0;
    int m_row = 0;
    int m_col = 0;
    logic [20:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write strobe must match the oldest predicted write
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst && ascii_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%02h expected none",
                         ascii_address, ascii_data);
            end else begin
                e = exp_q.pop_front();
                wr_seen++;
                if ({ascii_address, ascii_data} !== e) begin
                    failures++;
                    $display("FAIL write actual addr=%0d data=%02h expected addr=%0d data=%02h",
                             ascii_address, ascii_data, e[20:8], e[7:0]);
                end
            end
        end
    end

    // reference terminal model
    function automatic void push_line(input int r);
        for (int c = 0; c < COLS; c++) exp_q.push_back({13'(r * COLS + c), 8'h00});
    endfunction

    function automatic void push_screen();
        for (int a = 0; a < SCREEN; a++) exp_q.push_back({13'(a), 8'h00});
    endfunction

    function automatic void new_line();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        push_line(m_row);
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int cur;
        cur = m_row * COLS + m_col;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({13'(cur), b});
            if (m_col < COLS - 1) m_col++;
            else new_line();
        end else if (b == 8'h0A) begin
            new_line();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({13'(cur - 1), 8'h00});
            end
        end else if (b == 8'h0C) begin
            push_screen();
            m_row = 0;
            m_col = 0;
        end
    endfunction

    // driver tasks
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout byte=%02h", b);
            rx_valid = 1'b0;
            acc = -1;
            return;
        end
        model_accept(b);
        @(posedge clk);
        @(negedge clk);
        acc      = cyc;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (rx_ready !== 1'b1 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, int'(rx_ready), 1);
        check({name, "_cursor"}, int'(cursor), m_row * COLS + m_col);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic send_idle(input logic [7:0] b, input string name, output int n);
        int acc;
        send_byte(b, acc);
        wait_idle(name, n);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_ready"}, int'(rx_ready), 0);
        check({name, "_wr_en"}, int'(ascii_wr_en), 0);
        check({name, "_address"}, int'(ascii_address), 0);
        check({name, "_data"}, int'(ascii_data), 0);
        check({name, "_cursor"}, int'(cursor), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    function automatic logic [7:0] rand_mix();
        int r;
        logic [7:0] j;
        r = $urandom_range(0, 99);
        if (r < 70) return rand_print();
        if (r < 78) return 8'h0D;
        if (r < 86) return 8'h08;
        if (r < 90) return 8'h0A;
        j = 8'($urandom_range(0, 255));
        if ((j >= 8'h20 && j <= 8'h7E) || j == 8'h08 || j == 8'h0A || j == 8'h0C || j == 8'h0D)
            j = 8'h07;
        return j;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a1, a2, w0, k;
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // power-up clear of the whole screen
        rst = 1'b0;
        push_screen();
        wait_idle("powerup", n);

        // back-to-back printables with rx_valid held high
        send_byte(8'h41, a1);
        send_byte(8'h42, a2);
        check("accept_spacing", a2 - a1, 2);
        wait_idle("ab", n);

        send_idle(8'h0D, "cr_row0", n);
        check("cr_latency", n, 1);
        for (int i = 0; i < COLS - 1; i++) send_idle(rand_print(), "fill_row0", n);
        check("print_latency", n, 1);
        send_idle(8'h5A, "wrap_z", n);

        // backspace / carriage return / ignored byte on row 1
        for (int i = 0; i < 5; i++) send_idle(rand_print(), "to85", n);
        send_idle(8'h08, "bs85", n);
        send_idle(8'h0D, "cr84", n);
        send_idle(8'h08, "bs_col0", n);
        check("bs_col0_latency", n, 1);
        send_idle(8'h07, "ignored", n);
        check("ignored_latency", n, 1);

        // bottom-right printable wraps to row 0
        while (m_row != ROWS - 1) send_idle(8'h0A, "lf_down", n);
        for (int i = 0; i < COLS - 1; i++) send_idle(rand_print(), "fill_row59", n);
        send_idle(8'h51, "wrap_q", n);

        // line feed on the last row wraps to row 0
        while (m_row != ROWS - 1) send_idle(8'h0A, "lf_down2", n);
        send_idle(8'h0A, "lf_wrap", n);

        for (int i = 0; i < 150; i++) send_idle(rand_mix(), "mix", n);

        send_idle(8'h0C, "ff_full", n);
        for (int i = 0; i < 10; i++) send_idle(rand_mix(), "mix2", n);

        // reset in the middle of a full clear
        send_byte(8'h0C, a1);
        w0 = wr_seen;
        k  = 0;
        while (wr_seen < w0 + 100 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ff_writes_before_reset", int'(wr_seen >= w0 + 100), 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("midclear_reset");
        rst   = 1'b0;
        m_row = 0;
        m_col = 0;
        push_screen();
        wait_idle("restart_clear", n);
        send_idle(8'h48, "after_restart", n);

        repeat (3) @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
